serial_adder: RTL

- Bit-serial N-bit adder built around the single-bit full-adder cell (A, B, Cin -> Sout, Cout).
- Acts as the stage that feeds that cell. It latches two parallel operands, presents one bit pair per clock LSB-first, and registers the carry back into Cin.
- It collects the sum bits into a shift register and returns a parallel sum plus carry-out with a start/busy/done handshake.
- Used wherever area matters more than latency, e.g. small accumulators.

---
 rtl/serial_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches A/B/Cin, feeds one bit pair per clock LSB-first into a full-adder cell.
// Latency: start accepted at edge 0; Sout/Cout update and done pulses from edge WIDTH (one op per WIDTH+2 cycles).
// Backpressure: none; start is only sampled in IDLE, requests arriving in SHIFT/DONE are dropped.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sout,
   output logic             Cout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   // Only WIDTH-1 sum bits need storing: the newest bit joins them on the final
   // edge and goes straight to Sout, so the oldest bit never has to shift out.
   logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] sout_q, sout_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_bit;
   logic             c_next;

   // Full-adder cell fed by the current operand LSBs and the registered carry
   always_comb begin
      s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
      c_next   = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
      sum_next = {s_bit, sum_sr_q};
   end

   // Next-state logic and datapath updates for IDLE/SHIFT/DONE
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sout_d   = sout_q;
      c_d      = c_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d   = A;
               b_sr_d   = B;
               c_d      = Cin;
               cnt_d    = '0;
               sum_sr_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            sum_sr_d = sum_next[WIDTH-1:1];
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            c_d      = c_next;
            cnt_d    = cnt_q + CNT_W'(1);
            // Last bit pair: publish the full sum and the final carry together
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sout_d  = sum_next;
               cout_d  = c_next;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sout_q   <= '0;
         c_q      <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sout_q   <= sout_d;
         c_q      <= c_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign Sout = sout_q;
   assign Cout = cout_q;

endmodule
